// File: rtl/div_pkg.sv
// Shared types for the divide scheduler: state encoding and the queued divide uop.
package div_pkg;

   localparam int M_WIDTH        = 32;
   localparam int LG_ROB_ENTRIES = 6;
   localparam int LG_PRF_ENTRIES = 7;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } sched_state_t;

   typedef struct packed {
      logic [M_WIDTH-1:0]        srcA;
      logic [M_WIDTH-1:0]        srcB;
      logic                      is_signed;
      logic                      is_rem;
      logic [LG_ROB_ENTRIES-1:0] rob_ptr;
      logic [LG_PRF_ENTRIES-1:0] prf_ptr;
   } div_uop_t;

endpackage

// File: rtl/div_uop_fifo.sv
// Small circular FIFO of divide uops; the head entry is visible combinationally.
module div_uop_fifo
   import div_pkg::*;
#(
   parameter int LG_DQ = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   input  logic     push,
   input  logic     pop,
   input  div_uop_t din,
   output div_uop_t dout,
   output logic     full,
   output logic     empty
);

   localparam int             DQ     = 1 << LG_DQ;
   localparam logic [LG_DQ:0] DQ_CNT = (LG_DQ + 1)'(DQ);

   div_uop_t           mem_r [DQ];
   logic [LG_DQ-1:0]   head_r;
   logic [LG_DQ-1:0]   tail_r;
   logic [LG_DQ:0]     count_r;

   assign dout  = mem_r[head_r];
   assign full  = (count_r == DQ_CNT);
   assign empty = (count_r == {(LG_DQ + 1){1'b0}});

   // Storage and pointer update; pointers wrap naturally at DQ.
   always_ff @(posedge clk) begin
      if (!reset) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         for (int i = 0; i < DQ; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (push) begin
            mem_r[tail_r] <= din;
            tail_r        <= tail_r + 1'b1;
         end
         if (pop) begin
            head_r <= head_r + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/div_sched.sv
// Issue front end for the iterative divider: in-order uop queue, single outstanding
// divide, and a held writeback register with valid/ack toward the arbiter.
module div_sched
   import div_pkg::*;
#(
   parameter  int LG_DQ = 2,
   parameter  int LG_W  = 5,
   localparam int W     = 1 << LG_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      uop_valid,
   output logic                      uop_ready,
   input  logic [W-1:0]              uop_srcA,
   input  logic [W-1:0]              uop_srcB,
   input  logic                      uop_is_signed,
   input  logic                      uop_is_rem,
   input  logic [LG_ROB_ENTRIES-1:0] uop_rob_ptr,
   input  logic [LG_PRF_ENTRIES-1:0] uop_prf_ptr,
   output logic                      div_start,
   output logic [W-1:0]              div_inA,
   output logic [W-1:0]              div_inB,
   output logic                      div_is_signed,
   output logic                      div_is_rem,
   output logic [LG_ROB_ENTRIES-1:0] div_rob_ptr,
   output logic [LG_PRF_ENTRIES-1:0] div_prf_ptr,
   input  logic                      div_complete,
   input  logic [W-1:0]              div_y,
   input  logic [LG_ROB_ENTRIES-1:0] div_rob_ptr_in,
   input  logic [LG_PRF_ENTRIES-1:0] div_prf_ptr_in,
   output logic                      wb_valid,
   input  logic                      wb_ack,
   output logic [W-1:0]              wb_data,
   output logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr,
   output logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr,
   output logic                      busy
);

   div_uop_t     in_uop;
   div_uop_t     head_uop;
   logic         q_full;
   logic         q_empty;
   logic         q_push;
   sched_state_t state_r;
   logic         kill_r;

   assign in_uop = '{srcA:      uop_srcA,
                     srcB:      uop_srcB,
                     is_signed: uop_is_signed,
                     is_rem:    uop_is_rem,
                     rob_ptr:   uop_rob_ptr,
                     prf_ptr:   uop_prf_ptr};

   assign q_push = uop_valid & uop_ready;

   div_uop_fifo #(
      .LG_DQ (LG_DQ)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (q_push),
      .pop   (div_start),
      .din   (in_uop),
      .dout  (head_uop),
      .full  (q_full),
      .empty (q_empty)
   );

   assign div_inA       = head_uop.srcA;
   assign div_inB       = head_uop.srcB;
   assign div_is_signed = head_uop.is_signed;
   assign div_is_rem    = head_uop.is_rem;
   assign div_rob_ptr   = head_uop.rob_ptr;
   assign div_prf_ptr   = head_uop.prf_ptr;

   // Handshake, launch and busy decode; launch waits for a free or draining wb register.
   always_comb begin
      uop_ready = 1'b0;
      div_start = 1'b0;
      busy      = 1'b0;
      if (reset) begin
         uop_ready = !q_full && !flush;
         div_start = (state_r == S_IDLE) && !q_empty && (!wb_valid || wb_ack) && !flush;
         busy      = !q_empty || (state_r == S_BUSY) || wb_valid;
      end else begin
         uop_ready = 1'b0;
         div_start = 1'b0;
         busy      = 1'b0;
      end
   end

   // Scheduler state, kill tracking for a flushed in-flight divide, and the held result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= S_IDLE;
         kill_r     <= 1'b0;
         wb_valid   <= 1'b0;
         wb_data    <= '0;
         wb_rob_ptr <= '0;
         wb_prf_ptr <= '0;
      end else begin
         case (state_r)
            S_IDLE:  if (div_start)    state_r <= S_BUSY;
            S_BUSY:  if (div_complete) state_r <= S_IDLE;
            default: state_r <= S_IDLE;
         endcase

         // The divider cannot be aborted, so a flushed divide is remembered until it completes.
         if (div_complete) begin
            kill_r <= 1'b0;
         end else if (flush && (state_r == S_BUSY)) begin
            kill_r <= 1'b1;
         end

         if (flush) begin
            wb_valid <= 1'b0;
         end else if (div_complete && !kill_r) begin
            wb_valid   <= 1'b1;
            wb_data    <= div_y;
            wb_rob_ptr <= div_rob_ptr_in;
            wb_prf_ptr <= div_prf_ptr_in;
         end else if (wb_ack) begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Issue-side front end for the iterative `divider`. Drives its start/operand/tag inputs and consumes its y/complete outputs.
- Buffers divide uops from dispatch in a small in-order queue and launches one divide at a time.
- Captures each result into a held writeback register with a valid/ack handshake toward the writeback/complete arbiter.
- Handles pipeline flush, including a divide already in flight.

Parameters:
LG_DQ, 2, log2 of queue depth (DQ = 4 entries)
LG_W, 5, divider operand width log2; must match the divider instance (W = 32)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
flush  in  1  kill all queued, in-flight and held uops
uop_valid  in  1  dispatch offers a divide uop
uop_ready  out  1  queue can accept this cycle
uop_srcA  in  `M_WIDTH  dividend
uop_srcB  in  `M_WIDTH  divisor
uop_is_signed  in  1  signed op
uop_is_rem  in  1  remainder op
uop_rob_ptr  in  `LG_ROB_ENTRIES  ROB tag
uop_prf_ptr  in  `LG_PRF_ENTRIES  destination PRF tag
div_start  out  1  one-cycle launch to divider start_div
div_inA / div_inB  out  `M_WIDTH  operands to divider
div_is_signed / div_is_rem  out  1  op controls to divider
div_rob_ptr / div_prf_ptr  out  tag widths  to divider rob_ptr_in/prf_ptr_in
div_complete  in  1  divider complete
div_y  in  `M_WIDTH  divider result
div_rob_ptr_in / div_prf_ptr_in  in  tag widths  divider rob_ptr_out/prf_ptr_out
wb_valid  out  1  result held for writeback
wb_ack  in  1  arbiter accepts result this cycle
wb_data  out  `M_WIDTH  result
wb_rob_ptr / wb_prf_ptr  out  tag widths  result tags
busy  out  1  queue non-empty, divide in flight, or wb_valid

Behaviour:
- Reset (reset==0 at posedge clk) forces the following:
  - queue count, head and tail go to 0; state goes to S_IDLE; kill flag and wb_valid clear; wb_data and tags go to 0.
  - Combinational outputs while reset is low: uop_ready=0, div_start=0, busy=0.
  - Reset mid-divide: the divider is reset alongside this block, so no stale complete is expected.
- Queue: circular FIFO of DQ entries {srcA, srcB, signed, rem, rob, prf}.
  - uop_ready = (count != DQ) & !flush.
  - Enqueue on uop_valid & uop_ready. Pointers wrap modulo DQ.
  - Simultaneous push and pop leaves count unchanged; a push and a pop in the same cycle are legal even when the queue is full.
- State machine (enum sched_state_t):
  - S_IDLE (divider idle): div_start = !empty & (!wb_valid | wb_ack) & !flush.
  - The div_* operand and tag outputs are driven combinationally from the queue head in every cycle.
  - The head pops on div_start; transition to S_BUSY.
  - S_BUSY: wait for div_complete, then return to S_IDLE the next cycle. The divider is IDLE on that cycle, so back-to-back issue is legal.
- The divider's ready output is not consumed: it depends combinationally on start_div, and the scheduler's own state tracks the divider exactly.
- Latency, with start at cycle s: divider complete at s+W+2 (s+34); wb_valid=1 at s+W+3.
  - Enqueue into an empty idle queue at cycle t gives div_start at t+1.
- Capture: on div_complete & !kill, load wb_data=div_y and wb tags from div_*_in, and set wb_valid.
  - Issue is gated on a free or draining wb register, and only one divide is ever outstanding, so a capture never overwrites an unacked result.
- wb_valid stays set until wb_ack, which clears it. wb_data and tags are stable while wb_valid=1.
- Flush, in a flush cycle:
  - count goes to 0 and any enqueue that cycle is dropped.
  - wb_valid clears.
  - In S_BUSY, set kill. A complete arriving with kill set is discarded and clears kill.
  - The divider cannot be aborted, so the state remains S_BUSY until its complete.
- Flush in the same cycle as div_complete discards the result.
- Flush in the same cycle as wb_ack: the ack is ignored and the entry is gone.
- Division by zero and overflow follow divider arithmetic. This block passes results through unmodified.

Decomposition:
- Shared package div_pkg holds:
  - sched_state_t {S_IDLE, S_BUSY}
  - the div_uop_t packed struct (srcA, srcB, is_signed, is_rem, rob_ptr, prf_ptr)
- One natural sub-module: div_uop_fifo, a parameterised by LG_DQ storing div_uop_t, with push/pop/flush and full/empty.
- The divider itself is instantiated by the parent, not inside div_sched.

Test Plan:
- Unsigned 100/7, LG_W=5, idle → div_start 1 cycle after enqueue; wb_valid 35 cycles after start; wb_data=14, wb tags equal the enqueued tags.
- Signed rem, srcA=0xFFFFFFF9 (-7), srcB=2 → wb_data=0xFFFFFFFF (-1).
- Unsigned 5/0 → wb_data=0xFFFFFFFF; unsigned 5 rem 0 → wb_data=5.
- Enqueue 4 uops while a divide is busy → uop_ready=0 after the 4th; results emerge in order, with each next div_start exactly 1 cycle after the prior complete (wb_ack held 1).
- Hold wb_ack=0 with 2 queued → second div_start suppressed until the wb_ack cycle; div_start is asserted in the ack cycle.
- Flush 10 cycles after start with 2 queued → no wb_valid from that divide; queue empties; busy drops the cycle after div_complete; a new uop enqueued post-flush issues normally.
